// File: rtl/lsu_mem_ctrl_pkg.sv
// rtl/lsu_mem_ctrl_pkg.sv - riscv_defines: access types, mask modes, LSU states and helpers
// REQ2/WAIT2 states exist only when LSU_MISALIGN_SPLIT_EN is defined.
package riscv_defines;

    typedef enum logic [1:0] {
        MEM_DISABLED = 2'd0,
        MEM_READ     = 2'd1,
        MEM_WRITE    = 2'd2
    } memaccess_t;

    typedef enum logic [2:0] {
        MASK_BYTE   = 3'd0,
        MASK_BYTE_U = 3'd1,
        MASK_HALF   = 3'd2,
        MASK_HALF_U = 3'd3,
        MASK_WORD   = 3'd4
    } mask_mode_t;

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        REQ2  = 3'd3,
        WAIT2 = 3'd4
    } lsu_state_t;
`else
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } lsu_state_t;
`endif

    function automatic logic [3:0] size_mask(input mask_mode_t m);
        case (m)
            MASK_BYTE, MASK_BYTE_U: size_mask = 4'b0001;
            MASK_HALF, MASK_HALF_U: size_mask = 4'b0011;
            default:                size_mask = 4'b1111;
        endcase
    endfunction

    function automatic logic is_misaligned(input mask_mode_t m, input logic [1:0] off);
        case (m)
            MASK_HALF, MASK_HALF_U: is_misaligned = off[0];
            MASK_WORD:              is_misaligned = |off;
            default:                is_misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// rtl/lsu_mem_ctrl_if.sv - data memory bus between the LSU (master) and memory (slave)
interface lsu_mem_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl_load_align.sv
// rtl/lsu_mem_ctrl_load_align.sv - lsu_load_align: byte-offset extraction and sign/zero extension
// hi_i carries the low three bytes of a second beat; it is zero for single-beat loads.
module lsu_load_align
    import riscv_defines::*;
(
    input  logic [31:0] lo_i,
    input  logic [23:0] hi_i,
    input  logic [1:0]  off_i,
    input  mask_mode_t  mode_i,
    output logic [31:0] rdata_o
);
    logic [31:0] shifted;

    always_comb begin
        case (off_i)
            2'd0:    shifted = lo_i;
            2'd1:    shifted = {hi_i[7:0],  lo_i[31:8]};
            2'd2:    shifted = {hi_i[15:0], lo_i[31:16]};
            default: shifted = {hi_i[23:0], lo_i[31:24]};
        endcase
    end

    always_comb begin
        case (mode_i)
            MASK_BYTE:   rdata_o = {{24{shifted[7]}}, shifted[7:0]};
            MASK_BYTE_U: rdata_o = {24'd0, shifted[7:0]};
            MASK_HALF:   rdata_o = {{16{shifted[15]}}, shifted[15:0]};
            MASK_HALF_U: rdata_o = {16'd0, shifted[15:0]};
            default:     rdata_o = shifted;
        endcase
    end
endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - load/store unit memory controller, one outstanding access
// LSU_MISALIGN_SPLIT_EN: split word-crossing accesses into two bus beats instead of trapping.
module lsu_mem_ctrl
    import riscv_defines::*;
(
    input  logic           clk,
    input  logic           reset,
    input  logic           ex_valid,
    input  logic [31:0]    aluresult,
    input  memaccess_t     memaccess,
    input  mask_mode_t     mask_mode,
    input  logic [31:0]    wdata,
    output logic           lsu_stall,
    output logic           lsu_done,
    output logic [31:0]    rdata,
    output logic           datamisalign,
    lsu_mem_ctrl_if.master bus
);
    lsu_state_t  state_q, state_d;
    logic [31:0] addr_q, addr_d;
    mask_mode_t  mode_q, mode_d;
    logic [31:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        accept;
    logic        mem_req;
    logic [31:0] wdata_rot;
    logic [31:0] align_lo;
    logic [23:0] align_hi;

    assign accept = (state_q == IDLE) && ex_valid && (memaccess != MEM_DISABLED);

    // Rotation places every byte in its final lane for both beats of a split store.
    always_comb begin
        case (aluresult[1:0])
            2'd0:    wdata_rot = wdata;
            2'd1:    wdata_rot = {wdata[23:0], wdata[31:24]};
            2'd2:    wdata_rot = {wdata[15:0], wdata[31:16]};
            default: wdata_rot = {wdata[7:0],  wdata[31:8]};
        endcase
    end

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [31:0] first_q, first_d;
    logic [7:0]  be_wide;
    logic        crossing;
    logic        second_beat;

    assign be_wide       = {4'b0000, size_mask(mode_q)} << addr_q[1:0];
    assign crossing      = |be_wide[7:4];
    assign second_beat   = (state_q == REQ2) || (state_q == WAIT2);
    assign bus.mem_be    = second_beat ? be_wide[7:4] : be_wide[3:0];
    assign bus.mem_addr  = second_beat ? {addr_q[31:2] + 30'd1, 2'b00} : {addr_q[31:2], 2'b00};
    assign align_lo      = (state_q == WAIT2) ? first_q : bus.mem_rdata;
    assign align_hi      = (state_q == WAIT2) ? bus.mem_rdata[23:0] : 24'd0;
`else
    assign bus.mem_be    = size_mask(mode_q) << addr_q[1:0];
    assign bus.mem_addr  = {addr_q[31:2], 2'b00};
    assign align_lo      = bus.mem_rdata;
    assign align_hi      = 24'd0;
`endif

    assign bus.mem_req   = mem_req;
    assign bus.mem_we    = mem_req & we_q;
    assign bus.mem_wdata = wdata_q;

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        mode_d       = mode_q;
        wdata_d      = wdata_q;
        we_d         = we_q;
        lsu_stall    = 1'b0;
        lsu_done     = 1'b0;
        datamisalign = 1'b0;
        mem_req      = 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
        first_d      = first_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef LSU_MISALIGN_SPLIT_EN
                if (accept) begin
`else
                if (accept && is_misaligned(mask_mode, aluresult[1:0])) begin
                    datamisalign = 1'b1;
                end else if (accept) begin
`endif
                    addr_d    = aluresult;
                    mode_d    = mask_mode;
                    wdata_d   = wdata_rot;
                    we_d      = (memaccess == MEM_WRITE);
                    lsu_stall = 1'b1;
                    state_d   = REQ;
                end
            end
            REQ: begin
                mem_req   = 1'b1;
                lsu_stall = 1'b1;
                if (bus.mem_gnt) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (bus.mem_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
                    if (crossing) begin
                        first_d   = bus.mem_rdata;
                        lsu_stall = 1'b1;
                        state_d   = REQ2;
                    end else
`endif
                    begin
                        lsu_done = 1'b1;
                        state_d  = IDLE;
                    end
                end else begin
                    lsu_stall = 1'b1;
                end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            REQ2: begin
                mem_req   = 1'b1;
                lsu_stall = 1'b1;
                if (bus.mem_gnt) begin
                    state_d = WAIT2;
                end
            end
            WAIT2: begin
                if (bus.mem_rvalid) begin
                    lsu_done = 1'b1;
                    state_d  = IDLE;
                end else begin
                    lsu_stall = 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            addr_q  <= 32'd0;
            mode_q  <= MASK_BYTE;
            wdata_q <= 32'd0;
            we_q    <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            first_q <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mode_q  <= mode_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            first_q <= first_d;
`endif
        end
    end

    lsu_load_align u_load_align (
        .lo_i    (align_lo),
        .hi_i    (align_hi),
        .off_i   (addr_q[1:0]),
        .mode_i  (mode_q),
        .rdata_o (rdata)
    );
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - directed self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;
    import riscv_defines::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        ex_valid;
    logic [31:0] aluresult;
    memaccess_t  memaccess;
    mask_mode_t  mask_mode;
    logic [31:0] wdata;
    logic        lsu_stall;
    logic        lsu_done;
    logic [31:0] rdata;
    logic        datamisalign;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [31:0] addr;
        mask_mode_t  mode;
        logic [31:0] mem;
        logic [3:0]  be;
        logic [31:0] exp;
    } ld_vec_t;
    ld_vec_t ld_vecs [5];

    lsu_mem_ctrl_if bus();

    lsu_mem_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .ex_valid     (ex_valid),
        .aluresult    (aluresult),
        .memaccess    (memaccess),
        .mask_mode    (mask_mode),
        .wdata        (wdata),
        .lsu_stall    (lsu_stall),
        .lsu_done     (lsu_done),
        .rdata        (rdata),
        .datamisalign (datamisalign),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ex_valid       = 1'b0;
        aluresult      = 32'd0;
        memaccess      = MEM_DISABLED;
        mask_mode      = MASK_BYTE;
        wdata          = 32'd0;
        bus.mem_gnt    = 1'b0;
        bus.mem_rvalid = 1'b0;
        bus.mem_rdata  = 32'd0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        idle_inputs();
        step();
        @(negedge clk);
        checks++;
        if ({lsu_stall, lsu_done, datamisalign, bus.mem_req} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_outputs got=%b exp=0000", {lsu_stall, lsu_done, datamisalign, bus.mem_req});
        end
        step();
        reset = 1'b0;
    endtask

    task automatic test_load_byte;
        ex_valid = 1'b1; aluresult = 32'h0000_1003; memaccess = MEM_READ; mask_mode = MASK_BYTE;
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if ({lsu_stall, bus.mem_req, lsu_done} !== 3'b100) begin
            failures++;
            $display("FAIL lb_accept got=%b exp=100", {lsu_stall, bus.mem_req, lsu_done});
        end
        step();
        ex_valid = 1'b0; memaccess = MEM_DISABLED;
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, lsu_stall} !== {1'b1, 1'b0, 32'h0000_1000, 4'b1000, 1'b1}) begin
            failures++;
            $display("FAIL lb_request got=%h exp=%h", {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, lsu_stall},
                     {1'b1, 1'b0, 32'h0000_1000, 4'b1000, 1'b1});
        end
        step();
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h80FF_FF00;
        @(negedge clk);
        checks++;
        if ({lsu_done, lsu_stall, bus.mem_req} !== 3'b100) begin
            failures++;
            $display("FAIL lb_done got=%b exp=100", {lsu_done, lsu_stall, bus.mem_req});
        end
        checks++;
        if (rdata !== 32'hFFFF_FF80) begin
            failures++;
            $display("FAIL lb_rdata got=%h exp=ffffff80", rdata);
        end
        step();
        idle_inputs();
        @(negedge clk);
        checks++;
        if ({lsu_done, lsu_stall, bus.mem_req} !== 3'b000) begin
            failures++;
            $display("FAIL lb_back_idle got=%b exp=000", {lsu_done, lsu_stall, bus.mem_req});
        end
        step();
    endtask

    task automatic test_load_variants;
        ld_vecs[0] = '{32'h0000_4002, MASK_HALF_U, 32'h8001_1234, 4'b1100, 32'h0000_8001};
        ld_vecs[1] = '{32'h0000_4002, MASK_HALF,   32'h8001_1234, 4'b1100, 32'hFFFF_8001};
        ld_vecs[2] = '{32'h0000_4001, MASK_BYTE_U, 32'h0000_F000, 4'b0010, 32'h0000_00F0};
        ld_vecs[3] = '{32'h0000_4000, MASK_WORD,   32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF};
        ld_vecs[4] = '{32'h0000_4000, MASK_BYTE,   32'h0000_007F, 4'b0001, 32'h0000_007F};
        for (int i = 0; i < 5; i++) begin
            ex_valid = 1'b1; aluresult = ld_vecs[i].addr; memaccess = MEM_READ; mask_mode = ld_vecs[i].mode;
            bus.mem_gnt = 1'b1;
            step();
            ex_valid = 1'b0; memaccess = MEM_DISABLED;
            @(negedge clk);
            checks++;
            if ({bus.mem_req, bus.mem_addr, bus.mem_be} !== {1'b1, 32'h0000_4000, ld_vecs[i].be}) begin
                failures++;
                $display("FAIL load_req[%0d] got=%h exp=%h", i, {bus.mem_req, bus.mem_addr, bus.mem_be},
                         {1'b1, 32'h0000_4000, ld_vecs[i].be});
            end
            step();
            bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = ld_vecs[i].mem;
            @(negedge clk);
            checks++;
            if ({lsu_done, rdata} !== {1'b1, ld_vecs[i].exp}) begin
                failures++;
                $display("FAIL load_data[%0d] got=%h exp=%h", i, {lsu_done, rdata}, {1'b1, ld_vecs[i].exp});
            end
            step();
            idle_inputs();
        end
    endtask

    task automatic test_store_half;
        ex_valid = 1'b1; aluresult = 32'h0000_2002; memaccess = MEM_WRITE; mask_mode = MASK_HALF;
        wdata = 32'h0000_ABCD; bus.mem_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if ({lsu_stall, bus.mem_req} !== 2'b10) begin
            failures++;
            $display("FAIL sh_accept got=%b exp=10", {lsu_stall, bus.mem_req});
        end
        step();
        ex_valid = 1'b0; memaccess = MEM_DISABLED; wdata = 32'd0;
        for (int i = 0; i < 4; i++) begin
            bus.mem_gnt = (i == 3);
            @(negedge clk);
            checks++;
            if ({bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata[31:16], lsu_stall} !==
                {1'b1, 1'b1, 32'h0000_2000, 4'b1100, 16'hABCD, 1'b1}) begin
                failures++;
                $display("FAIL sh_hold[%0d] got=%h exp=%h", i,
                         {bus.mem_req, bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata[31:16], lsu_stall},
                         {1'b1, 1'b1, 32'h0000_2000, 4'b1100, 16'hABCD, 1'b1});
            end
            step();
        end
        bus.mem_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.mem_req, lsu_stall, lsu_done} !== 3'b010) begin
            failures++;
            $display("FAIL sh_wait got=%b exp=010", {bus.mem_req, lsu_stall, lsu_done});
        end
        step();
        bus.mem_rvalid = 1'b1;
        @(negedge clk);
        checks++;
        if ({lsu_done, lsu_stall} !== 2'b10) begin
            failures++;
            $display("FAIL sh_ack got=%b exp=10", {lsu_done, lsu_stall});
        end
        step();
        idle_inputs();
    endtask

    task automatic test_store_byte;
        ex_valid = 1'b1; aluresult = 32'h0000_5001; memaccess = MEM_WRITE; mask_mode = MASK_BYTE;
        wdata = 32'h0000_0055; bus.mem_gnt = 1'b1;
        step();
        ex_valid = 1'b0; memaccess = MEM_DISABLED;
        @(negedge clk);
        checks++;
        if ({bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata[15:8]} !== {1'b1, 32'h0000_5000, 4'b0010, 8'h55}) begin
            failures++;
            $display("FAIL sb_req got=%h exp=%h", {bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata[15:8]},
                     {1'b1, 32'h0000_5000, 4'b0010, 8'h55});
        end
        step();
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1;
        @(negedge clk);
        checks++;
        if (lsu_done !== 1'b1) begin
            failures++;
            $display("FAIL sb_done got=%b exp=1", lsu_done);
        end
        step();
        idle_inputs();
    endtask

`ifdef LSU_MISALIGN_SPLIT_EN
    task automatic test_split;
        ex_valid = 1'b1; aluresult = 32'h0000_3003; memaccess = MEM_READ; mask_mode = MASK_WORD;
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if ({lsu_stall, datamisalign} !== 2'b10) begin
            failures++;
            $display("FAIL split_accept got=%b exp=10", {lsu_stall, datamisalign});
        end
        step();
        ex_valid = 1'b0; memaccess = MEM_DISABLED;
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_be} !== {1'b1, 32'h0000_3000, 4'b1000}) begin
            failures++;
            $display("FAIL split_req1 got=%h exp=%h", {bus.mem_req, bus.mem_addr, bus.mem_be}, {1'b1, 32'h0000_3000, 4'b1000});
        end
        step();
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h1122_3344;
        @(negedge clk);
        checks++;
        if ({lsu_done, lsu_stall} !== 2'b01) begin
            failures++;
            $display("FAIL split_beat1 got=%b exp=01", {lsu_done, lsu_stall});
        end
        step();
        bus.mem_rvalid = 1'b0; bus.mem_gnt = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.mem_req, bus.mem_addr, bus.mem_be} !== {1'b1, 32'h0000_3004, 4'b0111}) begin
            failures++;
            $display("FAIL split_req2 got=%h exp=%h", {bus.mem_req, bus.mem_addr, bus.mem_be}, {1'b1, 32'h0000_3004, 4'b0111});
        end
        step();
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h5566_7788;
        @(negedge clk);
        checks++;
        if ({lsu_done, lsu_stall, rdata} !== {1'b1, 1'b0, 32'h6677_8811}) begin
            failures++;
            $display("FAIL split_done got=%h exp=%h", {lsu_done, lsu_stall, rdata}, {1'b1, 1'b0, 32'h6677_8811});
        end
        step();
        idle_inputs();
        ex_valid = 1'b1; aluresult = 32'h0000_3001; memaccess = MEM_READ; mask_mode = MASK_HALF;
        bus.mem_gnt = 1'b1;
        step();
        ex_valid = 1'b0; memaccess = MEM_DISABLED;
        @(negedge clk);
        checks++;
        if ({bus.mem_addr, bus.mem_be} !== {32'h0000_3000, 4'b0110}) begin
            failures++;
            $display("FAIL inword_half got=%h exp=%h", {bus.mem_addr, bus.mem_be}, {32'h0000_3000, 4'b0110});
        end
        step();
        bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b1;
        step();
        idle_inputs();
    endtask
`else
    task automatic test_misalign;
        for (int i = 0; i < 2; i++) begin
            ex_valid = 1'b1; memaccess = (i == 0) ? MEM_READ : MEM_WRITE;
            aluresult = (i == 0) ? 32'h0000_3001 : 32'h0000_3003;
            mask_mode = (i == 0) ? MASK_WORD : MASK_HALF;
            bus.mem_gnt = 1'b1;
            @(negedge clk);
            checks++;
            if ({datamisalign, bus.mem_req, lsu_stall} !== 3'b100) begin
                failures++;
                $display("FAIL misalign_pulse[%0d] got=%b exp=100", i, {datamisalign, bus.mem_req, lsu_stall});
            end
            step();
            idle_inputs();
            @(negedge clk);
            checks++;
            if ({datamisalign, bus.mem_req, lsu_stall} !== 3'b000) begin
                failures++;
                $display("FAIL misalign_after[%0d] got=%b exp=000", i, {datamisalign, bus.mem_req, lsu_stall});
            end
            step();
        end
    endtask
`endif

    task automatic test_reset_mid;
        ex_valid = 1'b1; aluresult = 32'h0000_6000; memaccess = MEM_READ; mask_mode = MASK_WORD;
        bus.mem_gnt = 1'b1;
        step();
        ex_valid = 1'b0; memaccess = MEM_DISABLED;
        step();
        bus.mem_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.mem_req, lsu_stall} !== 2'b01) begin
            failures++;
            $display("FAIL rst_in_wait got=%b exp=01", {bus.mem_req, lsu_stall});
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.mem_rvalid = 1'b1; bus.mem_gnt = 1'b1; bus.mem_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        checks++;
        if ({lsu_done, bus.mem_req, lsu_stall} !== 3'b000) begin
            failures++;
            $display("FAIL rst_late_rvalid got=%b exp=000", {lsu_done, bus.mem_req, lsu_stall});
        end
        step();
        bus.mem_rvalid = 1'b0; bus.mem_gnt = 1'b0;
        @(negedge clk);
        checks++;
        if ({lsu_done, bus.mem_req, lsu_stall} !== 3'b000) begin
            failures++;
            $display("FAIL rst_settled got=%b exp=000", {lsu_done, bus.mem_req, lsu_stall});
        end
        step();
    endtask

    initial begin
        test_reset();
        test_load_byte();
        test_load_variants();
        test_store_half();
        test_store_byte();
`ifdef LSU_MISALIGN_SPLIT_EN
        test_split();
`else
        test_misalign();
`endif
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lsu_mem_ctrl.md
LSU_MEM_CTRL -- requirements
Module: lsu_mem_ctrl

Interface
REQ-001 clk  in  1  sole clock; all state updates on rising edge.
REQ-002 reset  in  1  synchronous, active-high reset.
REQ-003 ex_valid  in  1  MEM-stage instruction valid.
REQ-004 aluresult  in  32  effective byte address.
REQ-005 memaccess  in  memaccess_t  MEM_DISABLED / MEM_READ / MEM_WRITE.
REQ-006 mask_mode  in  mask_mode_t  MASK_BYTE, MASK_BYTE_U, MASK_HALF, MASK_HALF_U, MASK_WORD.
REQ-007 wdata  in  32  store data, right-aligned.
REQ-008 lsu_stall  out  1  pipeline hold.
REQ-009 lsu_done  out  1  one-cycle completion pulse.
REQ-010 rdata  out  32  extended load result, valid with lsu_done.
REQ-011 datamisalign  out  1  one-cycle misaligned-access exception pulse.
REQ-012 mem_req, mem_we  out  1 each  bus request, write strobe.
REQ-013 mem_addr  out  32  word-aligned address, bits [1:0] always 0.
REQ-014 mem_be  out  4  byte enables.
REQ-015 mem_wdata  out  32  lane-positioned store data.
REQ-016 mem_gnt, mem_rvalid  in  1 each  request accepted; read data or write ack returned.
REQ-017 mem_rdata  in  32  read data, valid with mem_rvalid.

Function
REQ-018 States: IDLE, REQ, WAIT, REQ2, WAIT2; REQ2 and WAIT2 are present only with the split feature.
REQ-019 Accept condition: IDLE && ex_valid && memaccess!=MEM_DISABLED; the block latches address, mode, data and direction, then enters REQ.
REQ-020 Misaligned access: half/half_u with addr[0]=1, or word with addr[1:0]!=0.
REQ-021 Misaligned access without split: datamisalign=1 in the accept cycle, no bus request, no stall, state stays IDLE.
REQ-022 In REQ/REQ2, mem_req=1 with addr, be, we and wdata held stable until mem_gnt; on grant, move to WAIT/WAIT2.
REQ-023 Grant latency is 0..N cycles; at most one transaction is outstanding.
REQ-024 In WAIT/WAIT2, mem_req=0; mem_rvalid completes the access (writes included).
REQ-025 On the final mem_rvalid: lsu_done=1, rdata is valid, return to IDLE.
REQ-026 lsu_stall = accepted legal access in IDLE, or state in REQ/WAIT/REQ2, or WAIT/WAIT2 without final rvalid.
REQ-027 lsu_stall=0 in the lsu_done cycle.
REQ-028 Byte enables, off=addr[1:0]: byte 0001<<off; half 0011<<off; word 1111.
REQ-029 Store data is rotated left by 8*off; unused lanes are don't-care.
REQ-030 Load data is shifted right by 8*off, then extended: BYTE/HALF sign-extend; BYTE_U/HALF_U zero-extend; WORD unchanged.
REQ-031 mem_rvalid in IDLE is ignored, and mem_gnt outside REQ/REQ2 is ignored.

Reset
REQ-032 Reset returns the block to IDLE and clears every output register; lsu_stall, lsu_done, datamisalign and mem_req are all 0 the cycle after reset is sampled.
REQ-033 Reset mid-transaction abandons the access; the late rvalid is ignored per REQ-031.

Configuration
REQ-034 Macro LSU_MISALIGN_SPLIT_EN.
REQ-035 When the macro is undefined, behaviour follows REQ-021.
REQ-036 When the macro is defined, datamisalign is tied 0.
REQ-037 With the macro defined, an access that stays inside one word (e.g. half at off=1) uses a single access with be 0110.
REQ-038 With the macro defined, a word-crossing access issues two transactions: first at A (be = (mask<<off)[3:0]), second at A+4 modulo 2^32 (be = mask>>(4-off)).
REQ-039 For a split load, the first beat is held in a register, {second,first} is shifted right by 8*off, then extended; lsu_done is asserted only on the second rvalid.

Structure
REQ-040 memaccess_t, mask_mode_t and the state enum belong in riscv_defines.
REQ-041 The load extraction/extension logic is the sub-module lsu_load_align.

Verification
REQ-042 Scenario: LB from 0x1003, mem_rdata=0x80FF_FF00, gnt and rvalid immediate -> mem_addr=0x1000, be=1000, rdata=0xFFFF_FF80, done on the third cycle.
REQ-043 Scenario: SH 0xABCD to 0x2002, gnt held low for 3 cycles -> mem_req, addr and be=1100 stable throughout, mem_wdata[31:16]=0xABCD, stall high until the ack.
REQ-044 Scenario: LW from 0x3001 without the macro -> datamisalign pulse, mem_req stays 0, lsu_stall=0.
REQ-045 Scenario: LW from 0x3003 with the macro, beats 0x11223344 then 0x55667788 -> addresses 0x3000/0x3004, be 1000/0111, rdata=0x66778811.
REQ-046 Scenario: reset asserted in WAIT, then rvalid arrives -> state IDLE, no lsu_done, mem_req=0.
